f3_keydebounce: RTL and testbench

//  Upstream front end of the function-3 key processor. Takes the five raw, asynchronous push-button

---
 rtl/f3_keydebounce_if.sv | 21 ++
 rtl/f3_keydebounce.sv | 117 +++++++++++
 tb/tb_f3_keydebounce.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/f3_keydebounce_if.sv
// rtl/f3_keydebounce_if.sv - raw key levels in, debounced levels and press pulses out
// master drives the raw buttons; slave is the debouncer.
interface f3_keydebounce_if #(
  parameter int NKEYS = 5
);
  logic [NKEYS-1:0] raw_keys;
  logic [NKEYS-1:0] func3_keys;
  logic [NKEYS-1:0] key_level;

  modport master (
    output raw_keys,
    input  func3_keys,
    input  key_level
  );

  modport slave (
    input  raw_keys,
    output func3_keys,
    output key_level
  );
endinterface

// File: rtl/f3_keydebounce.sv
// rtl/f3_keydebounce.sv - per-key synchroniser, debouncer, press pulse and optional auto-repeat
// Every channel is independent; the downstream priority encoder arbitrates between keys.
module f3_keydebounce #(
  parameter int               NKEYS         = 5,
  parameter int               DEBOUNCE_CYC  = 500000,
  parameter int               REPEAT_EN     = 0,
  parameter logic [NKEYS-1:0] REPEAT_MASK   = 5'b11110,
  parameter int               REPEAT_DELAY  = 25000000,
  parameter int               REPEAT_PERIOD = 10000000,
  parameter int               CNT_W         = 25
) (
  input  logic                sysclk,
  input  logic                reset,
  f3_keydebounce_if.slave     keys
);

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_PERIOD = 2'd2
  } rstate_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  // Repeat counters compare against the full delay/period value: a pulse lands
  // REPEAT_DELAY+1 edges after the accepted press and REPEAT_PERIOD+1 edges apart.
  localparam logic [CNT_W-1:0] RD_TERM = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_TERM = CNT_W'(REPEAT_PERIOD);
  localparam logic [NKEYS-1:0] REP_ON  = (REPEAT_EN != 0) ? REPEAT_MASK : '0;

  logic [NKEYS-1:0] s1;
  logic [NKEYS-1:0] s2;
  logic [NKEYS-1:0] lvl;
  logic [NKEYS-1:0] pulse;
  logic [CNT_W-1:0] dcnt [NKEYS];
  logic [CNT_W-1:0] rcnt [NKEYS];
  rstate_t          rstate [NKEYS];

  logic [NKEYS-1:0] settle;
  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] rel;
  logic [NKEYS-1:0] fire;

  always_comb begin
    settle = '0;
    fire   = '0;
    for (int i = 0; i < NKEYS; i++) begin
      settle[i] = (s2[i] != lvl[i]) && (dcnt[i] == DB_LAST);
    end
    press = settle & s2;
    rel   = settle & ~s2;
    for (int i = 0; i < NKEYS; i++) begin
      if (REP_ON[i] && (rstate[i] != R_IDLE) && !rel[i]) begin
        fire[i] = (rcnt[i] == ((rstate[i] == R_DELAY) ? RD_TERM : RP_TERM));
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      pulse <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        dcnt[i]   <= '0;
        rcnt[i]   <= '0;
        rstate[i] <= R_IDLE;
      end
    end else begin
      s1    <= keys.raw_keys;
      s2    <= s1;
      pulse <= press | fire;
      for (int i = 0; i < NKEYS; i++) begin
        // Any cycle where the synchronised level matches restarts the count.
        if (s2[i] == lvl[i]) begin
          dcnt[i] <= '0;
        end else if (settle[i]) begin
          dcnt[i] <= '0;
          lvl[i]  <= s2[i];
        end else begin
          dcnt[i] <= dcnt[i] + CNT_W'(1);
        end

        if (!REP_ON[i]) begin
          rstate[i] <= R_IDLE;
          rcnt[i]   <= '0;
        end else begin
          case (rstate[i])
            R_IDLE: begin
              rcnt[i] <= '0;
              if (press[i]) rstate[i] <= R_DELAY;
            end
            R_DELAY, R_PERIOD: begin
              if (rel[i]) begin
                rstate[i] <= R_IDLE;
                rcnt[i]   <= '0;
              end else if (fire[i]) begin
                rstate[i] <= R_PERIOD;
                rcnt[i]   <= '0;
              end else begin
                rcnt[i] <= rcnt[i] + CNT_W'(1);
              end
            end
            default: begin
              rstate[i] <= R_IDLE;
              rcnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign keys.func3_keys = pulse;
  assign keys.key_level  = lvl;

endmodule

// File: tb/tb_f3_keydebounce.sv
// tb/tb_f3_keydebounce.sv - directed vectors for f3_keydebounce, plain and auto-repeat builds
// dut_a has repeat disabled, dut_r repeats with DELAY=20, PERIOD=5; both debounce over 8 cycles.
module tb_f3_keydebounce;

  logic sysclk = 1'b0;
  logic reset;

  always #5 sysclk = ~sysclk;

  f3_keydebounce_if #(.NKEYS(5)) ifa ();
  f3_keydebounce_if #(.NKEYS(5)) ifr ();

  f3_keydebounce #(
    .NKEYS(5), .DEBOUNCE_CYC(8), .REPEAT_EN(0), .REPEAT_MASK(5'b11110),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .CNT_W(8)
  ) dut_a (
    .sysclk(sysclk),
    .reset (reset),
    .keys  (ifa)
  );

  f3_keydebounce #(
    .NKEYS(5), .DEBOUNCE_CYC(8), .REPEAT_EN(1), .REPEAT_MASK(5'b11110),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .CNT_W(8)
  ) dut_r (
    .sysclk(sysclk),
    .reset (reset),
    .keys  (ifr)
  );

  typedef struct {
    logic [4:0] raw;
    logic [4:0] pulse;
    logic [4:0] lvl;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ecnt   = 0;
  int   base   = 0;
  int   cnt_a[5];
  int   cnt_r[5];
  int   q3[$];
  int   exp4[6] = '{10, 31, 37, 43, 49, 55};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_raw(input logic [4:0] v);
    ifa.raw_keys = v;
    ifr.raw_keys = v;
  endtask

  // One rising edge, then sample on the falling edge.
  task automatic step();
    @(negedge sysclk);
    ecnt++;
    for (int k = 0; k < 5; k++) begin
      if (ifa.func3_keys[k]) cnt_a[k]++;
      if (ifr.func3_keys[k]) cnt_r[k]++;
    end
    if (ifr.func3_keys[3]) q3.push_back(ecnt - base);
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 5; k++) begin
      cnt_a[k] = 0;
      cnt_r[k] = 0;
    end
    q3.delete();
    base = ecnt;
  endtask

  task automatic settle_release();
    set_raw(5'b0);
    repeat (12) step();
    check("release lvl a", 32'(ifa.key_level), 32'h0);
    check("release lvl r", 32'(ifr.key_level), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    set_raw(5'b0);
    clr_counts();
    repeat (3) @(negedge sysclk);
    check("reset pulse a", 32'(ifa.func3_keys), 32'h0);
    check("reset lvl a",   32'(ifa.key_level),  32'h0);
    check("reset pulse r", 32'(ifr.func3_keys), 32'h0);
    check("reset lvl r",   32'(ifr.key_level),  32'h0);
    reset = 1'b0;

    // Clean press of key2, its release, then keys 1 and 4 together.
    for (int k = 1; k <= 12; k++)
      tbl.push_back('{5'b00100, (k == 10) ? 5'b00100 : 5'b0, (k >= 10) ? 5'b00100 : 5'b0});
    for (int k = 1; k <= 12; k++)
      tbl.push_back('{5'b00000, 5'b0, (k < 10) ? 5'b00100 : 5'b0});
    for (int k = 1; k <= 12; k++)
      tbl.push_back('{5'b10010, (k == 10) ? 5'b10010 : 5'b0, (k >= 10) ? 5'b10010 : 5'b0});

    foreach (tbl[j]) begin
      set_raw(tbl[j].raw);
      step();
      check($sformatf("vec%0d pulse a", j), 32'(ifa.func3_keys), 32'(tbl[j].pulse));
      check($sformatf("vec%0d lvl a", j),   32'(ifa.key_level),  32'(tbl[j].lvl));
      check($sformatf("vec%0d pulse r", j), 32'(ifr.func3_keys), 32'(tbl[j].pulse));
    end

    // Reset while keys 1 and 4 are held and accepted, then again mid-debounce.
    reset = 1'b1;
    step();
    check("rst held pulse a", 32'(ifa.func3_keys), 32'h0);
    check("rst held lvl a",   32'(ifa.key_level),  32'h0);
    check("rst held lvl r",   32'(ifr.key_level),  32'h0);
    reset = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    check("rst mid lvl a", 32'(ifa.key_level), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 9) check("post rst early pulse", 32'(ifa.func3_keys), 32'h0);
      if (k == 10) begin
        check("post rst pulse a", 32'(ifa.func3_keys), 32'h12);
        check("post rst pulse r", 32'(ifr.func3_keys), 32'h12);
        check("post rst lvl a",   32'(ifa.key_level),  32'h12);
      end
      if (k == 11) check("post rst pulse end", 32'(ifa.func3_keys), 32'h0);
    end
    settle_release();

    // Key4 bounces every 3 cycles for 40 cycles, then holds.
    clr_counts();
    for (int c = 0; c < 40; c++) begin
      set_raw(((c / 3) % 2 == 0) ? 5'b10000 : 5'b00000);
      step();
    end
    check("bounce pulses a", 32'(cnt_a[4]), 32'd0);
    check("bounce pulses r", 32'(cnt_r[4]), 32'd0);
    check("bounce lvl a",    32'(ifa.key_level), 32'h0);
    set_raw(5'b10000);
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 9)  check("bounce pre pulse", 32'(ifa.func3_keys), 32'h0);
      if (k == 10) check("bounce pulse",     32'(ifa.func3_keys), 32'h10);
      if (k == 11) check("bounce pulse end", 32'(ifa.func3_keys), 32'h0);
    end
    check("bounce total a", 32'(cnt_a[4]), 32'd1);
    settle_release();

    // Long hold of key0, release, press again.
    clr_counts();
    set_raw(5'b00001);
    repeat (100) step();
    set_raw(5'b00000);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9)  check("k0 lvl before fall", 32'(ifa.key_level[0]), 32'd1);
      if (k == 10) check("k0 lvl fall",        32'(ifa.key_level[0]), 32'd0);
    end
    set_raw(5'b00001);
    repeat (15) step();
    check("k0 two presses a", 32'(cnt_a[0]), 32'd2);
    check("k0 two presses r", 32'(cnt_r[0]), 32'd2);
    settle_release();

    // Auto-repeat on key3, none on masked key0, none at all on dut_a.
    clr_counts();
    set_raw(5'b01001);
    repeat (50) step();
    set_raw(5'b00000);
    repeat (20) step();
    check("rpt count", 32'(q3.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < q3.size()) check($sformatf("rpt edge%0d", i), 32'(q3[i]), 32'(exp4[i]));
    end
    check("rpt k0 single r", 32'(cnt_r[0]), 32'd1);
    check("rpt k3 single a", 32'(cnt_a[3]), 32'd1);
    check("rpt k0 single a", 32'(cnt_a[0]), 32'd1);
    check("rpt lvl r", 32'(ifr.key_level), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
